if_inst_queue: RTL and testbench

Instruction queue between the fetch-side PC register stage and the decode stage. Each cycle it captures the registered fetch PC and its valid flag together with the instruction word returned by instruction memory for that PC. It holds up to DEPTH pairs so decode stalls do not lose in-flight fetches, and presents a registered {pc, inst, valid} triple to decode. Backpressure goes to fetch through a stall request; branch and flush empty the queue.

---
 rtl/if_inst_queue_pkg.sv | 33 +++
 rtl/if_inst_queue_mem.sv | 24 ++
 rtl/if_inst_queue.sv | 114 +++++++++++
 tb/tb_if_inst_queue.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/if_inst_queue_pkg.sv
// Shared constants and per-cycle operation decode for the fetch-to-decode instruction queue.
package if_inst_queue_pkg;

  localparam logic STOP         = 1'b1;
  localparam logic NO_STOP      = 1'b0;
  localparam logic INST_VALID   = 1'b1;
  localparam logic INST_INVALID = 1'b0;

  localparam int STALL_W    = 7;
  localparam int STALL_ID   = 2;
  localparam int STALL_EXE  = 3;

  typedef enum logic [1:0] {
    OP_CLEAR  = 2'd0,
    OP_BUBBLE = 2'd1,
    OP_HOLD   = 2'd2,
    OP_RUN    = 2'd3
  } q_op_e;

  // Redirects outrank stalls so a flushed fetch can never linger in the queue.
  function automatic q_op_e decode_op(input logic branch, input logic flush,
                                      input logic stall_id, input logic stall_exe);
    if (branch || flush)
      return OP_CLEAR;
    else if (stall_id == STOP && stall_exe == NO_STOP)
      return OP_BUBBLE;
    else if (stall_id == STOP)
      return OP_HOLD;
    else
      return OP_RUN;
  endfunction

endpackage

// File: rtl/if_inst_queue_mem.sv
// Queue storage: register array, one synchronous write port, one asynchronous read port.
module if_inst_queue_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/if_inst_queue.sv
// Instruction queue between the fetch PC stage and decode; absorbs in-flight fetches during decode stalls.
module if_inst_queue
  import if_inst_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic               pc_valid_i,
  input  logic [INST_W-1:0]  inst_i,
  input  logic               flush,
  input  logic               branch_flag_i,
  input  logic [STALL_W-1:0] stall,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [INST_W-1:0]  inst_o,
  output logic               inst_valid_o,
  output logic               stall_req_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + INST_W;

  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_pc;
  logic [INST_W-1:0] r_inst;
  logic              r_valid;

  q_op_e             w_op;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic [ENT_W-1:0]  w_rdata;

  assign w_op    = decode_op(branch_flag_i, flush, stall[STALL_ID], stall[STALL_EXE]);
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_pop   = (w_op == OP_RUN) && !w_empty;
  // An empty, running queue bypasses the input straight to the output instead of storing it.
  assign w_push  = pc_valid_i && (w_op != OP_CLEAR) && !((w_op == OP_RUN) && w_empty)
                   && (!w_full || w_pop);

  if_inst_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (w_push),
    .waddr (r_tail),
    .wdata ({pc_i, inst_i}),
    .raddr (r_head),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_pc    <= '0;
      r_inst  <= '0;
      r_valid <= INST_INVALID;
    end else if (w_op == OP_CLEAR) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_pc    <= '0;
      r_inst  <= '0;
      r_valid <= INST_INVALID;
    end else begin
      if (w_push)
        r_tail <= r_tail + 1'b1;
      if (w_pop)
        r_head <= r_head + 1'b1;
      if (w_push && !w_pop)
        r_count <= r_count + 1'b1;
      else if (w_pop && !w_push)
        r_count <= r_count - 1'b1;

      if (w_op == OP_BUBBLE) begin
        r_pc    <= '0;
        r_inst  <= '0;
        r_valid <= INST_INVALID;
      end else if (w_op == OP_RUN) begin
        if (!w_empty) begin
          r_pc    <= w_rdata[ENT_W-1:INST_W];
          r_inst  <= w_rdata[INST_W-1:0];
          r_valid <= INST_VALID;
        end else if (pc_valid_i) begin
          r_pc    <= pc_i;
          r_inst  <= inst_i;
          r_valid <= INST_VALID;
        end else begin
          r_pc    <= '0;
          r_inst  <= '0;
          r_valid <= INST_INVALID;
        end
      end
    end
  end

  assign pc_o         = r_pc;
  assign inst_o       = r_inst;
  assign inst_valid_o = r_valid;
  assign stall_req_o  = (r_count >= CNT_W'(DEPTH - 1));

endmodule

// File: tb/tb_if_inst_queue.sv
// Directed bench for if_inst_queue: bypass, fill/drain, bubble, branch, wrap-around and async reset.
`timescale 1ns/1ps
module tb_if_inst_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] pc_i;
  logic              pc_valid_i;
  logic [INST_W-1:0] inst_i;
  logic              flush;
  logic              branch_flag_i;
  logic [6:0]        stall;
  logic [ADDR_W-1:0] pc_o;
  logic [INST_W-1:0] inst_o;
  logic              inst_valid_o;
  logic              stall_req_o;

  int n_checks = 0;
  int n_errors = 0;

  if_inst_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_i          (pc_i),
    .pc_valid_i    (pc_valid_i),
    .inst_i        (inst_i),
    .flush         (flush),
    .branch_flag_i (branch_flag_i),
    .stall         (stall),
    .pc_o          (pc_o),
    .inst_o        (inst_o),
    .inst_valid_o  (inst_valid_o),
    .stall_req_o   (stall_req_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h0280_0000;
  endfunction

  // Advances one clock; also confirms fetch never pushes into a full queue.
  task automatic step();
    logic ovf;
    ovf = pc_valid_i && !branch_flag_i && !flush && stall[2] && (dut.r_count == 3'(DEPTH));
    check_val("no_push_when_full", 64'(ovf), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [6:0] st);
    pc_valid_i = v;
    pc_i       = pc;
    inst_i     = inst_of(pc);
    stall      = st;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] pc, input int cnt);
    check_val({tag, "_valid"}, 64'(inst_valid_o), 64'(v));
    check_val({tag, "_pc"}, 64'(pc_o), 64'(pc));
    check_val({tag, "_inst"}, 64'(inst_o), v ? 64'(inst_of(pc)) : 64'd0);
    check_val({tag, "_count"}, 64'(dut.r_count), 64'(cnt));
    check_val({tag, "_stallreq"}, 64'(stall_req_o), 64'(cnt >= DEPTH - 1));
  endtask

  logic [31:0] prev_pc;
  logic [31:0] cur_pc;

  initial begin
    rst = 1'b0; flush = 1'b0; branch_flag_i = 1'b0;
    drive(1'b0, 32'h0, 7'b0);
    #12;
    expect_out("reset", 1'b0, 32'h0, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Bypass
    drive(1'b1, 32'h1C00_0000, 7'b0);
    step();
    expect_out("bypass", 1'b1, 32'h1C00_0000, 0);

    // Fill under full stall, output held
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h1C00_0000 + 32'(4 * i), 7'b0001100);
      step();
      expect_out($sformatf("fill%0d", i), 1'b1, 32'h1C00_0000, i + 1);
    end
    drive(1'b0, 32'h0, 7'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      expect_out($sformatf("drain%0d", i), 1'b1, 32'h1C00_0000 + 32'(4 * i), 3 - i);
    end
    step();
    expect_out("drain_empty", 1'b0, 32'h0, 0);

    // Bubble with two queued
    drive(1'b1, 32'h1C00_0010, 7'b0001100); step();
    drive(1'b1, 32'h1C00_0014, 7'b0001100); step();
    drive(1'b0, 32'h0, 7'b0000100); step();
    expect_out("bubble", 1'b0, 32'h0, 2);
    drive(1'b0, 32'h0, 7'b0); step();
    expect_out("bubble_rel0", 1'b1, 32'h1C00_0010, 1);
    step();
    expect_out("bubble_rel1", 1'b1, 32'h1C00_0014, 0);

    // Branch mid-queue
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h1C00_0020 + 32'(4 * i), 7'b0001100);
      step();
    end
    check_val("pre_branch_stallreq", 64'(stall_req_o), 64'd1);
    drive(1'b1, 32'h1C00_002C, 7'b0);
    branch_flag_i = 1'b1;
    step();
    branch_flag_i = 1'b0;
    expect_out("branch", 1'b0, 32'h0, 0);
    drive(1'b1, 32'h1C00_8000, 7'b0); step();
    expect_out("post_branch_bypass", 1'b1, 32'h1C00_8000, 0);

    // Flush with queued entries
    drive(1'b1, 32'h1C00_9000, 7'b0001100); step();
    drive(1'b1, 32'h1C00_9004, 7'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    expect_out("flush", 1'b0, 32'h0, 0);

    // Wrap-around with count steady at 1
    drive(1'b1, 32'h1C00_1000, 7'b0001100); step();
    prev_pc = 32'h1C00_1000;
    for (int k = 0; k < 10; k++) begin
      cur_pc = 32'h1C00_1004 + 32'(4 * k);
      drive(1'b1, cur_pc, 7'b0);
      step();
      expect_out($sformatf("wrap%0d", k), 1'b1, prev_pc, 1);
      prev_pc = cur_pc;
    end
    drive(1'b0, 32'h0, 7'b0); step();
    expect_out("wrap_last", 1'b1, prev_pc, 0);

    // Async reset mid-clock with three queued, output held valid
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h1C00_0030 + 32'(4 * i), 7'b0001100);
      step();
    end
    expect_out("pre_reset", 1'b1, prev_pc, 3);
    #2;
    rst = 1'b0;
    #1;
    expect_out("async_reset", 1'b0, 32'h0, 0);
    drive(1'b0, 32'h0, 7'b0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    expect_out("after_reset", 1'b0, 32'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
